cpu_control_sequencer: RTL and testbench
========================================

# cpu_control_sequencer

Hardwired control unit that sequences the ArithmeticLogicUnitSystem datapath through fetch, decode and execute. It drives every datapath control input from a 4-state FSM plus a decode of `IROut` and `ALU_FlagsOut`, and implements a 6-opcode subset: BRA, BNE, MOVL, ADD, STB, HLT. It is the top-level controller placed beside the datapath in the CPU.

## Interface
No parameters.

- `Clock` in 1: rising-edge clock shared with the datapath.
- `Reset` in 1: asynchronous, active-low.
- `IROut` in 16: instruction register contents.
- `ALU_FlagsOut` in 4: {Z,C,N,O}, with Z at bit 3.
- `State` out 2: FSM state; FETCH_L=00, FETCH_H=01, EXEC=10, HALT=11.
- `Mem_CS` out 1: memory chip select, active-low.
- `Mem_WR` out 1: memory direction; 1 = write.
- `IR_Write` out 1: IR load enable.
- `IR_LH` out 1: IR byte select; 0 = low, 1 = high.
- `ALU_WF` out 1: flag write enable.
- `ALU_FunSel` out 5: 5'b10000 = pass A; 5'b10100 = A+B.
- `RF_OutASel`, `RF_OutBSel` out 3 each: 000..011 select R1..R4.
- `RF_FunSel` out 3: 3'b010 = load.
- `RF_RegSel` out 4: one-hot enables, bit0 = R1 … bit3 = R4.
- `RF_ScrSel` out 4: always 0.
- `ARF_RegSel` out 3: enables; bit2 = PC, bit1 = AR, bit0 = SP.
- `ARF_FunSel` out 2: 01 = increment, 10 = load.
- `ARF_OutCSel`, `ARF_OutDSel` out 2 each: 00 = PC, 10 = AR.
- `MuxASel`, `MuxBSel` out 2 each: 11 = {24'b0, IROut[7:0]}.
- `MuxCSel` out 2, `MuxDSel` out 1: always 0 in this subset.
- `DR_E` out 1, `DR_FunSel` out 2: always 0.

## Operation
- **Idle vector.** Mem_CS=1 and every other output 0. It is driven whenever `Reset`=0, in HALT, and for any field not listed below.
- **Output decode.** Outputs are combinational from `State`, `IROut` and `ALU_FlagsOut`. `State` is the only register.
- **FETCH_L.**
  - Drive ARF_OutDSel=00, Mem_CS=0, Mem_WR=0, IR_Write=1, IR_LH=0, ARF_RegSel=100, ARF_FunSel=01.
  - Edge effect: IR[7:0]←M[PC], PC←PC+1.
  - Next state: FETCH_H.
- **FETCH_H.** Same signals as FETCH_L with IR_LH=1. Edge effect: IR[15:8]←M[PC], PC+1. Next state: EXEC.
- **EXEC.** Decode opcode = IROut[15:10]. Next state is FETCH_L unless stated otherwise.
  - 0x00 BRA: MuxBSel=11, ARF_RegSel=100, ARF_FunSel=10; PC←IR[7:0].
  - 0x01 BNE: BRA signals only if ALU_FlagsOut[3]=0; otherwise the idle vector.
  - 0x02 MOVL: MuxASel=11, RF_FunSel=010, RF_RegSel=onehot(IR[9:8]); Rd←IR[7:0].
  - 0x03 ADD:
    - Signals: RF_OutASel={0,IR[5:4]}, RF_OutBSel={0,IR[3:2]}, MuxDSel=0, ALU_FunSel=10100, ALU_WF=1, MuxASel=00, RF_FunSel=010, RF_RegSel=onehot(IR[9:8]).
    - Effect: Rd←Rs1+Rs2, flags updated.
    - Rd may equal a source; the old value is used because the write happens at the edge.
  - 0x04 STB: RF_OutASel={0,IR[9:8]}, ALU_FunSel=10000, MuxCSel=00, ARF_OutDSel=10, Mem_CS=0, Mem_WR=1; M[AR]←Rx[7:0].
  - 0x05 HLT: idle vector; next state HALT.
  - 0x06–0x3F: idle vector, treated as NOP.
- **HALT.** Absorbing state; only `Reset` leaves it.

## Timing
- **Reset.** Asynchronous: `State`→FETCH_L immediately and all outputs take the idle vector while `Reset`=0, even mid-instruction. The first fetch happens in the first cycle after release.
- **Instruction length.** Every non-HLT instruction takes exactly 3 cycles: FETCH_L, FETCH_H, EXEC.
- **Memory read.** Memory read data is valid within the same cycle as its address, so there are no wait states.
- **BNE flags.** BNE samples Z in EXEC, i.e. the flags written by the most recent ADD, including an ADD in the immediately preceding instruction.
- **PC wrap.** PC wraps 0xFFFF→0x0000; this is ARF behaviour and needs no controller handling.
- **HLT latency.** HLT reaches HALT 3 cycles after its fetch starts. From then on no memory access occurs: Mem_CS=1.

## Test plan
- **Reset.** Assert Reset=0 mid-EXEC of ADD → State=00, RF_RegSel=0, Mem_CS=1 immediately; after release, FETCH_L drives IR_Write=1, IR_LH=0, ARF_RegSel=100.
- **MOVL/ADD.** Memory holds MOVL R1,0x05; MOVL R2,0xFB; ADD R3,R1,R2 → after 9 cycles R3=0x100, and the ADD EXEC cycle shows ALU_FunSel=10100, ALU_WF=1, RF_RegSel=0100.
- **BNE.** Z=0 → PC←IR[7:0]; Z=1 → ARF_RegSel=000 and PC continues sequentially.
- **STB.** AR=0x0040, R4=0x12 with IR=0x1300 → in EXEC Mem_WR=1, Mem_CS=0, ARF_OutDSel=10, ALU_FunSel=10000; M[0x40]=0x12.
- **HLT/illegal.** Opcode 0x3F → one idle EXEC cycle, then fetch resumes at PC+2. HLT → State=11 held for 100 cycles with Mem_CS=1.

Source files
------------

// File: rtl/cpu_ctrl_if.sv
// Control/status bundle between the hardwired sequencer and the
// ArithmeticLogicUnitSystem datapath.
interface cpu_ctrl_if;
  logic [15:0] IROut;
  logic [3:0]  ALU_FlagsOut;
  logic [1:0]  State;
  logic        Mem_CS;
  logic        Mem_WR;
  logic        IR_Write;
  logic        IR_LH;
  logic        ALU_WF;
  logic [4:0]  ALU_FunSel;
  logic [2:0]  RF_OutASel;
  logic [2:0]  RF_OutBSel;
  logic [2:0]  RF_FunSel;
  logic [3:0]  RF_RegSel;
  logic [3:0]  RF_ScrSel;
  logic [2:0]  ARF_RegSel;
  logic [1:0]  ARF_FunSel;
  logic [1:0]  ARF_OutCSel;
  logic [1:0]  ARF_OutDSel;
  logic [1:0]  MuxASel;
  logic [1:0]  MuxBSel;
  logic [1:0]  MuxCSel;
  logic        MuxDSel;
  logic        DR_E;
  logic [1:0]  DR_FunSel;

  modport master (
    input  IROut, ALU_FlagsOut,
    output State, Mem_CS, Mem_WR, IR_Write, IR_LH,
    output ALU_WF, ALU_FunSel,
    output RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
    output ARF_RegSel, ARF_FunSel, ARF_OutCSel, ARF_OutDSel,
    output MuxASel, MuxBSel, MuxCSel, MuxDSel,
    output DR_E, DR_FunSel
  );

  modport slave (
    output IROut, ALU_FlagsOut,
    input  State, Mem_CS, Mem_WR, IR_Write, IR_LH,
    input  ALU_WF, ALU_FunSel,
    input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
    input  ARF_RegSel, ARF_FunSel, ARF_OutCSel, ARF_OutDSel,
    input  MuxASel, MuxBSel, MuxCSel, MuxDSel,
    input  DR_E, DR_FunSel
  );
endinterface

// File: rtl/cpu_control_sequencer.sv
// Hardwired FETCH_L/FETCH_H/EXEC sequencer for the 6-opcode subset
// (BRA, BNE, MOVL, ADD, STB, HLT); outputs decode from state and IR.
module cpu_control_sequencer (
  input  logic        Clock,
  input  logic        Reset,
  cpu_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    FETCH_L = 2'b00,
    FETCH_H = 2'b01,
    EXEC    = 2'b10,
    HALT    = 2'b11
  } state_e;

  state_e state_q, state_d;

  logic [5:0] opcode;
  logic [3:0] rd_oh;
  logic       unused_bits;

  assign opcode      = bus.IROut[15:10];
  assign rd_oh       = 4'b0001 << bus.IROut[9:8];
  assign unused_bits = ^{bus.IROut[7:6], bus.IROut[1:0],
                         bus.ALU_FlagsOut[2:0]};
  assign bus.State   = state_q;

  always_comb begin
    state_d         = state_q;
    bus.Mem_CS      = 1'b1;
    bus.Mem_WR      = 1'b0;
    bus.IR_Write    = 1'b0;
    bus.IR_LH       = 1'b0;
    bus.ALU_WF      = 1'b0;
    bus.ALU_FunSel  = 5'b0;
    bus.RF_OutASel  = 3'b0;
    bus.RF_OutBSel  = 3'b0;
    bus.RF_FunSel   = 3'b0;
    bus.RF_RegSel   = 4'b0;
    bus.RF_ScrSel   = 4'b0;
    bus.ARF_RegSel  = 3'b0;
    bus.ARF_FunSel  = 2'b0;
    bus.ARF_OutCSel = 2'b0;
    bus.ARF_OutDSel = 2'b0;
    bus.MuxASel     = 2'b0;
    bus.MuxBSel     = 2'b0;
    bus.MuxCSel     = 2'b0;
    bus.MuxDSel     = 1'b0;
    bus.DR_E        = 1'b0;
    bus.DR_FunSel   = 2'b0;
    // Outputs stay idle for as long as reset is held, even mid-instruction.
    if (Reset) begin
      unique case (state_q)
        FETCH_L, FETCH_H: begin
          bus.Mem_CS     = 1'b0;
          bus.IR_Write   = 1'b1;
          bus.IR_LH      = (state_q == FETCH_H);
          bus.ARF_RegSel = 3'b100;
          bus.ARF_FunSel = 2'b01;
          state_d = (state_q == FETCH_L) ? FETCH_H : EXEC;
        end
        EXEC: begin
          state_d = FETCH_L;
          case (opcode)
            6'h00: begin
              bus.MuxBSel    = 2'b11;
              bus.ARF_RegSel = 3'b100;
              bus.ARF_FunSel = 2'b10;
            end
            6'h01: begin
              if (!bus.ALU_FlagsOut[3]) begin
                bus.MuxBSel    = 2'b11;
                bus.ARF_RegSel = 3'b100;
                bus.ARF_FunSel = 2'b10;
              end
            end
            6'h02: begin
              bus.MuxASel   = 2'b11;
              bus.RF_FunSel = 3'b010;
              bus.RF_RegSel = rd_oh;
            end
            6'h03: begin
              bus.RF_OutASel = {1'b0, bus.IROut[5:4]};
              bus.RF_OutBSel = {1'b0, bus.IROut[3:2]};
              bus.ALU_FunSel = 5'b10100;
              bus.ALU_WF     = 1'b1;
              bus.RF_FunSel  = 3'b010;
              bus.RF_RegSel  = rd_oh;
            end
            6'h04: begin
              bus.RF_OutASel  = {1'b0, bus.IROut[9:8]};
              bus.ALU_FunSel  = 5'b10000;
              bus.ARF_OutDSel = 2'b10;
              bus.Mem_CS      = 1'b0;
              bus.Mem_WR      = 1'b1;
            end
            6'h05: state_d = HALT;
            default: ;
          endcase
        end
        HALT: ;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= FETCH_L;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Scoreboard bench: a tiny datapath model runs a fixed program while a
// monitor compares each cycle's control vector against queued expectations.
module tb_cpu_control_sequencer;

  typedef struct packed {
    logic [1:0]  st;
    logic        cs, wr, irw, irlh;
    logic [2:0]  arf_rs;
    logic [1:0]  arf_fs, arf_d, mux_a, mux_b;
    logic [4:0]  alu_fs;
    logic        wf;
    logic [2:0]  rf_a, rf_b, rf_fs;
    logic [3:0]  rf_rs;
    logic [11:0] zz;
  } ctl_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   vec_idx = 0;
  ctl_t sbq[$];

  cpu_ctrl_if bus ();

  cpu_control_sequencer dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] pc, ar, ir;
  logic [15:0] rf [4];
  logic [3:0]  flg;
  logic [7:0]  rom [256];
  logic [7:0]  st_mem [256];
  logic [15:0] alu_a, alu_b, alu_o, mux_a, maddr;
  logic [7:0]  mrd;

  assign bus.IROut        = ir;
  assign bus.ALU_FlagsOut = flg;

  always_comb begin
    alu_a = rf[bus.RF_OutASel[1:0]];
    alu_b = rf[bus.RF_OutBSel[1:0]];
    alu_o = (bus.ALU_FunSel == 5'b10100) ? alu_a + alu_b : alu_a;
    mux_a = (bus.MuxASel == 2'b11) ? {8'h00, ir[7:0]} : alu_o;
    maddr = (bus.ARF_OutDSel == 2'b10) ? ar : pc;
    mrd   = rom[maddr[7:0]];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc  <= 16'h0000;
      ar  <= 16'h0040;
      ir  <= 16'h0000;
      flg <= 4'h0;
      for (int i = 0; i < 4; i++) rf[i] <= 16'h0000;
    end else begin
      if (!bus.Mem_CS && bus.Mem_WR) st_mem[maddr[7:0]] <= alu_o[7:0];
      if (!bus.Mem_CS && bus.IR_Write) begin
        if (bus.IR_LH) ir[15:8] <= mrd;
        else           ir[7:0]  <= mrd;
      end
      if (bus.ARF_RegSel[2]) begin
        if (bus.ARF_FunSel == 2'b01) pc <= pc + 16'h1;
        if (bus.ARF_FunSel == 2'b10) pc <= {8'h00, ir[7:0]};
      end
      if (bus.RF_FunSel == 3'b010)
        for (int i = 0; i < 4; i++)
          if (bus.RF_RegSel[i]) rf[i] <= mux_a;
      if (bus.ALU_WF) flg <= {alu_o == 16'h0, 3'b000};
    end
  end

  function automatic ctl_t cur();
    ctl_t c;
    c.st     = bus.State;
    c.cs     = bus.Mem_CS;
    c.wr     = bus.Mem_WR;
    c.irw    = bus.IR_Write;
    c.irlh   = bus.IR_LH;
    c.arf_rs = bus.ARF_RegSel;
    c.arf_fs = bus.ARF_FunSel;
    c.arf_d  = bus.ARF_OutDSel;
    c.mux_a  = bus.MuxASel;
    c.mux_b  = bus.MuxBSel;
    c.alu_fs = bus.ALU_FunSel;
    c.wf     = bus.ALU_WF;
    c.rf_a   = bus.RF_OutASel;
    c.rf_b   = bus.RF_OutBSel;
    c.rf_fs  = bus.RF_FunSel;
    c.rf_rs  = bus.RF_RegSel;
    c.zz     = {bus.RF_ScrSel, bus.MuxCSel, bus.MuxDSel,
                bus.DR_E, bus.DR_FunSel, bus.ARF_OutCSel};
    return c;
  endfunction

  function automatic ctl_t idle(input logic [1:0] s);
    ctl_t c = '0;
    c.st = s;
    c.cs = 1'b1;
    return c;
  endfunction

  function automatic ctl_t fetch(input logic lh);
    ctl_t c = '0;
    c.st     = {1'b0, lh};
    c.irw    = 1'b1;
    c.irlh   = lh;
    c.arf_rs = 3'b100;
    c.arf_fs = 2'b01;
    return c;
  endfunction

  function automatic ctl_t bra();
    ctl_t c = idle(2'b10);
    c.mux_b  = 2'b11;
    c.arf_rs = 3'b100;
    c.arf_fs = 2'b10;
    return c;
  endfunction

  function automatic ctl_t movl(input int rd);
    ctl_t c = idle(2'b10);
    c.mux_a = 2'b11;
    c.rf_fs = 3'b010;
    c.rf_rs = 4'(1 << rd);
    return c;
  endfunction

  function automatic ctl_t add(input int rd, input int a, input int b);
    ctl_t c = idle(2'b10);
    c.rf_a   = 3'(a);
    c.rf_b   = 3'(b);
    c.alu_fs = 5'b10100;
    c.wf     = 1'b1;
    c.rf_fs  = 3'b010;
    c.rf_rs  = 4'(1 << rd);
    return c;
  endfunction

  function automatic ctl_t stb(input int rx);
    ctl_t c = idle(2'b10);
    c.cs     = 1'b0;
    c.wr     = 1'b1;
    c.rf_a   = 3'(rx);
    c.alu_fs = 5'b10000;
    c.arf_d  = 2'b10;
    return c;
  endfunction

  task automatic push_instr(input ctl_t ex);
    sbq.push_back(fetch(1'b0));
    sbq.push_back(fetch(1'b1));
    sbq.push_back(ex);
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic chk_ctl(input string nm, input ctl_t got, input ctl_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic wait_empty(input int lim);
    for (int i = 0; i < lim && sbq.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout pending=%0d exp=0", sbq.size());
      sbq.delete();
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && sbq.size() > 0) begin
      ctl_t e, a;
      e = sbq.pop_front();
      a = cur();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL ctl[%0d] got=%h exp=%h", vec_idx, a, e);
      end
      vec_idx++;
    end
  end

  task automatic put_word(input int addr, input logic [15:0] w);
    rom[addr]     = w[7:0];
    rom[addr + 1] = w[15:8];
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    put_word(8'h00, 16'h0805);
    put_word(8'h02, 16'h09FB);
    put_word(8'h04, 16'h0E04);
    put_word(8'h06, 16'h040A);
    put_word(8'h08, 16'h1400);
    put_word(8'h0A, 16'h0B12);
    put_word(8'h0C, 16'h1300);
    put_word(8'h0E, 16'h0800);
    put_word(8'h10, 16'h0D00);
    put_word(8'h12, 16'h0430);
    put_word(8'h14, 16'hFC00);
    put_word(8'h16, 16'h1400);

    repeat (3) @(posedge clk);
    #1;
    chk_ctl("reset_idle", cur(), idle(2'b00));

    push_instr(movl(0));
    push_instr(movl(1));
    push_instr(add(2, 0, 1));
    push_instr(bra());
    push_instr(movl(3));
    push_instr(stb(3));
    push_instr(movl(0));
    push_instr(add(1, 0, 0));
    push_instr(idle(2'b10));
    push_instr(idle(2'b10));
    push_instr(idle(2'b10));
    for (int i = 0; i < 100; i++) sbq.push_back(idle(2'b11));

    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_empty(400);

    chk("r3_sum", 32'(rf[2]), 32'h0100);
    chk("r4_movl", 32'(rf[3]), 32'h0012);
    chk("r2_zero", 32'(rf[1]), 32'h0000);
    chk("mem40_stb", 32'(st_mem[8'h40]), 32'h12);
    chk("pc_halt", 32'(pc), 32'h0018);
    chk("z_flag", 32'(flg), 32'h8);

    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk_ctl("halt_reset_idle", cur(), idle(2'b00));
    push_instr(movl(0));
    push_instr(movl(1));
    push_instr(add(2, 0, 1));
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_empty(100);

    #1 rst_n = 1'b0;
    #1;
    chk_ctl("mid_exec_reset", cur(), idle(2'b00));
    chk("mid_exec_state", 32'(bus.State), 32'h0);
    push_instr(movl(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_empty(50);
    @(posedge clk);
    #1;
    chk("r1_after_reset", 32'(rf[0]), 32'h0005);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
